// File: rtl/btb_port_ctrl.sv
// Single-port BTB array arbiter: fetch lookups win the port, resolved-branch updates queue in a FIFO.
// After reset an INIT sweep clears every entry before lookups can hit.
module btb_port_ctrl #(
  parameter int unsigned W_PC    = 8,
  parameter int unsigned W_BTA   = 32,
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         fetch_req,
  input  logic [W_PC-1:0]                              fetch_pc,
  output logic                                         fetch_vld,
  output logic                                         fetch_hit,
  output logic [W_BTA-1:0]                             fetch_bta,
  input  logic                                         ex_valid,
  input  logic                                         ex_taken,
  input  logic                                         ex_predicted,
  input  logic [W_PC-1:0]                              ex_pc,
  input  logic [W_BTA-1:0]                             ex_target,
  output logic                                         upd_ready,
  output logic                                         upd_drop,
  output logic                                         init_done,
  output logic                                         arr_en,
  output logic                                         arr_we,
  output logic [$clog2(ENTRIES)-1:0]                   arr_idx,
  output logic [W_PC-2-$clog2(ENTRIES)+W_BTA:0]        arr_wdata,
  input  logic [W_PC-2-$clog2(ENTRIES)+W_BTA:0]        arr_rdata
);

  localparam int unsigned IDXW = $clog2(ENTRIES);
  localparam int unsigned TAGW = W_PC - 2 - IDXW;
  localparam int unsigned EW   = 1 + TAGW + W_BTA;
  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   init_idx_q, init_idx_d;
  logic [EW-1:0]     fifo_data_q [DEPTH];
  logic [EW-1:0]     fifo_data_d [DEPTH];
  logic [IDXW-1:0]   fifo_idx_q [DEPTH];
  logic [IDXW-1:0]   fifo_idx_d [DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              lk_req_q, lk_req_d, lk_perf_q, lk_perf_d;
  logic [TAGW-1:0]   lk_tag_q, lk_tag_d;
  logic              upd_ready_q, upd_ready_d;
  logic              upd_drop_q, upd_drop_d;
  logic              init_done_q, init_done_d;

  logic              arr_en_c, arr_we_c;
  logic [IDXW-1:0]   arr_idx_c;
  logic [EW-1:0]     arr_wdata_c;
  logic              fifo_full, enq, deq, grant, upd_qual;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Port arbitration, FIFO bookkeeping and lookup capture
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    fifo_data_d = fifo_data_q;
    fifo_idx_d  = fifo_idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    arr_en_c    = 1'b0;
    arr_we_c    = 1'b0;
    arr_idx_c   = '0;
    arr_wdata_c = '0;
    enq         = 1'b0;
    deq         = 1'b0;
    grant       = 1'b0;
    upd_drop_d  = 1'b0;
    fifo_full   = (count_q == CNTW'(DEPTH));
    upd_qual    = ex_valid & (ex_taken ^ ex_predicted);

    case (state_q)
      S_INIT: begin
        arr_en_c  = 1'b1;
        arr_we_c  = 1'b1;
        arr_idx_c = init_idx_q;
        if (init_idx_q == IDXW'(ENTRIES - 1)) begin
          state_d    = S_RUN;
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + IDXW'(1);
        end
      end
      default: begin
        if (fifo_full || (!fetch_req && count_q != '0)) begin
          arr_en_c    = 1'b1;
          arr_we_c    = 1'b1;
          arr_idx_c   = fifo_idx_q[rd_ptr_q];
          arr_wdata_c = fifo_data_q[rd_ptr_q];
          deq         = 1'b1;
        end else if (fetch_req) begin
          arr_en_c  = 1'b1;
          arr_idx_c = fetch_pc[IDXW+1:2];
          grant     = 1'b1;
        end
      end
    endcase

    // Taken-but-unpredicted installs the target; predicted-but-not-taken invalidates
    if (upd_qual) begin
      if (fifo_full) begin
        upd_drop_d = 1'b1;
      end else begin
        enq                   = 1'b1;
        fifo_idx_d[wr_ptr_q]  = ex_pc[IDXW+1:2];
        fifo_data_d[wr_ptr_q] = {ex_taken, ex_pc[W_PC-1:IDXW+2],
                                 ex_taken ? ex_target : W_BTA'(0)};
        wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
    end
    if (deq) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    count_d     = count_q + CNTW'(enq) - CNTW'(deq);
    upd_ready_d = (count_d < CNTW'(DEPTH));
    init_done_d = (state_d == S_RUN);
    lk_req_d    = fetch_req;
    lk_perf_d   = grant;
    lk_tag_d    = fetch_pc[W_PC-1:IDXW+2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INIT;
      init_idx_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lk_req_q    <= 1'b0;
      lk_perf_q   <= 1'b0;
      lk_tag_q    <= '0;
      upd_ready_q <= 1'b0;
      upd_drop_q  <= 1'b0;
      init_done_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lk_req_q    <= lk_req_d;
      lk_perf_q   <= lk_perf_d;
      lk_tag_q    <= lk_tag_d;
      upd_ready_q <= upd_ready_d;
      upd_drop_q  <= upd_drop_d;
      init_done_q <= init_done_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data_q[i] <= fifo_data_d[i];
        fifo_idx_q[i]  <= fifo_idx_d[i];
      end
    end
  end

  // Lookup result resolves against the array read data one cycle after the request
  logic            rd_valid;
  logic [TAGW-1:0] rd_tag;
  assign rd_valid  = arr_rdata[EW-1];
  assign rd_tag    = arr_rdata[EW-2 -: TAGW];
  assign fetch_vld = lk_req_q;
  assign fetch_hit = lk_req_q & lk_perf_q & rd_valid & (rd_tag == lk_tag_q);
  assign fetch_bta = fetch_hit ? arr_rdata[W_BTA-1:0] : '0;

  assign upd_ready = upd_ready_q;
  assign upd_drop  = upd_drop_q;
  assign init_done = init_done_q;
  assign arr_en    = arr_en_c & reset;
  assign arr_we    = arr_we_c & reset;
  assign arr_idx   = arr_idx_c;
  assign arr_wdata = arr_wdata_c;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], ex_pc[1:0]};

endmodule

// File: tb/tb_btb_port_ctrl.sv
// Directed bench for btb_port_ctrl: INIT sweep, lookup/update arbitration, FIFO full/drop, reset mid-drain.
module tb_btb_port_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [7:0]  fetch_pc;
  logic        fetch_vld, fetch_hit;
  logic [31:0] fetch_bta;
  logic        ex_valid, ex_taken, ex_predicted;
  logic [7:0]  ex_pc;
  logic [31:0] ex_target;
  logic        upd_ready, upd_drop, init_done;
  logic        arr_en, arr_we;
  logic [1:0]  arr_idx;
  logic [36:0] arr_wdata, arr_rdata;
  logic [36:0] mem [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btb_port_ctrl dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_vld(fetch_vld), .fetch_hit(fetch_hit), .fetch_bta(fetch_bta),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_predicted(ex_predicted),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .upd_ready(upd_ready), .upd_drop(upd_drop), .init_done(init_done),
    .arr_en(arr_en), .arr_we(arr_we), .arr_idx(arr_idx),
    .arr_wdata(arr_wdata), .arr_rdata(arr_rdata)
  );

  // Synchronous-read storage array
  always @(posedge clk) begin
    if (arr_en) begin
      if (arr_we) mem[arr_idx] <= arr_wdata;
      else        arr_rdata    <= mem[arr_idx];
    end
  end

  typedef struct {
    logic        freq;
    logic [7:0]  fpc;
    logic        exv, ext, exp;
    logic [7:0]  expc;
    logic [31:0] tgt;
    logic        vld, hit;
    logic [31:0] bta;
    logic        rdy, drop, en, we;
    logic [1:0]  idx;
    logic [36:0] wd;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t v(logic freq, logic [7:0] fpc, logic exv, logic ext, logic exp,
                             logic [7:0] expc, logic [31:0] tgt, logic vld, logic hit,
                             logic [31:0] bta, logic rdy, logic drop, logic en, logic we,
                             logic [1:0] idx, logic [36:0] wd);
    vec_t r;
    r.freq = freq; r.fpc = fpc; r.exv = exv; r.ext = ext; r.exp = exp; r.expc = expc;
    r.tgt = tgt; r.vld = vld; r.hit = hit; r.bta = bta; r.rdy = rdy; r.drop = drop;
    r.en = en; r.we = we; r.idx = idx; r.wd = wd;
    return r;
  endfunction

  function automatic logic [36:0] wd(logic vb, logic [3:0] tag, logic [31:0] bta);
    return {vb, tag, bta};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic drive(input logic freq, input logic [7:0] fpc, input logic exv,
                       input logic ext, input logic exp, input logic [7:0] expc,
                       input logic [31:0] tgt);
    fetch_req = freq; fetch_pc = fpc; ex_valid = exv; ex_taken = ext;
    ex_predicted = exp; ex_pc = expc; ex_target = tgt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_init_sweep(input string tag);
    for (int i = 0; i < 4; i++) begin
      drive(i == 1, 8'h14, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clk);
      chk($sformatf("%s_en%0d", tag, i), 64'(arr_en), 64'd1);
      chk($sformatf("%s_we%0d", tag, i), 64'(arr_we), 64'd1);
      chk($sformatf("%s_idx%0d", tag, i), 64'(arr_idx), 64'(i));
      chk($sformatf("%s_wd%0d", tag, i), 64'(arr_wdata), 64'd0);
      chk($sformatf("%s_done%0d", tag, i), 64'(init_done), 64'd0);
      if (i == 2) begin
        chk($sformatf("%s_fvld", tag), 64'(fetch_vld), 64'd1);
        chk($sformatf("%s_fhit", tag), 64'(fetch_hit), 64'd0);
      end
      next_cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk($sformatf("%s_done", tag), 64'(init_done), 64'd1);
    chk($sformatf("%s_idle_en", tag), 64'(arr_en), 64'd0);
    next_cycle();
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);

    //       freq fpc    exv ext exp expc   tgt        vld hit bta       rdy drop en we idx wd
    vecs[0]  = v(0, 8'h00, 1, 1, 0, 8'h14, 32'h40,   0, 0, 32'h0,   1, 0, 0, 0, 0, 0);
    vecs[1]  = v(0, 8'h00, 0, 0, 0, 8'h00, 32'h0,    0, 0, 32'h0,   1, 0, 1, 1, 1, wd(1, 1, 32'h40));
    vecs[2]  = v(1, 8'h14, 0, 0, 0, 8'h00, 32'h0,    0, 0, 32'h0,   1, 0, 1, 0, 1, 0);
    vecs[3]  = v(0, 8'h00, 0, 0, 0, 8'h00, 32'h0,    1, 1, 32'h40,  1, 0, 0, 0, 0, 0);
    vecs[4]  = v(1, 8'h04, 0, 0, 0, 8'h00, 32'h0,    0, 0, 32'h0,   1, 0, 1, 0, 1, 0);
    vecs[5]  = v(0, 8'h00, 0, 0, 0, 8'h00, 32'h0,    1, 0, 32'h0,   1, 0, 0, 0, 0, 0);
    vecs[6]  = v(1, 8'h14, 1, 1, 0, 8'h28, 32'h80,   0, 0, 32'h0,   1, 0, 1, 0, 1, 0);
    vecs[7]  = v(1, 8'h14, 1, 1, 0, 8'h3C, 32'hC0,   1, 1, 32'h40,  1, 0, 1, 0, 1, 0);
    vecs[8]  = v(1, 8'h14, 1, 1, 0, 8'h30, 32'h11,   1, 1, 32'h40,  0, 0, 1, 1, 2, wd(1, 2, 32'h80));
    vecs[9]  = v(1, 8'h14, 0, 0, 0, 8'h00, 32'h0,    1, 0, 32'h0,   1, 1, 1, 0, 1, 0);
    vecs[10] = v(0, 8'h00, 0, 0, 0, 8'h00, 32'h0,    1, 1, 32'h40,  1, 0, 1, 1, 3, wd(1, 3, 32'hC0));
    vecs[11] = v(1, 8'h30, 0, 0, 0, 8'h00, 32'h0,    0, 0, 32'h0,   1, 0, 1, 0, 0, 0);
    vecs[12] = v(0, 8'h00, 0, 0, 0, 8'h00, 32'h0,    1, 0, 32'h0,   1, 0, 0, 0, 0, 0);
    vecs[13] = v(1, 8'h28, 0, 0, 0, 8'h00, 32'h0,    0, 0, 32'h0,   1, 0, 1, 0, 2, 0);
    vecs[14] = v(1, 8'h3C, 0, 0, 0, 8'h00, 32'h0,    1, 1, 32'h80,  1, 0, 1, 0, 3, 0);
    vecs[15] = v(0, 8'h00, 0, 0, 0, 8'h00, 32'h0,    1, 1, 32'hC0,  1, 0, 0, 0, 0, 0);
    vecs[16] = v(0, 8'h00, 1, 0, 1, 8'h14, 32'h0,    0, 0, 32'h0,   1, 0, 0, 0, 0, 0);
    vecs[17] = v(0, 8'h00, 0, 0, 0, 8'h00, 32'h0,    0, 0, 32'h0,   1, 0, 1, 1, 1, wd(0, 1, 32'h0));
    vecs[18] = v(1, 8'h14, 0, 0, 0, 8'h00, 32'h0,    0, 0, 32'h0,   1, 0, 1, 0, 1, 0);
    vecs[19] = v(0, 8'h00, 0, 0, 0, 8'h00, 32'h0,    1, 0, 32'h0,   1, 0, 0, 0, 0, 0);
    vecs[20] = v(0, 8'h00, 1, 1, 1, 8'h28, 32'h99,   0, 0, 32'h0,   1, 0, 0, 0, 0, 0);
    vecs[21] = v(0, 8'h00, 1, 0, 0, 8'h3C, 32'h77,   0, 0, 32'h0,   1, 0, 0, 0, 0, 0);
    vecs[22] = v(0, 8'h00, 1, 1, 0, 8'h04, 32'h55,   0, 0, 32'h0,   1, 0, 0, 0, 0, 0);
    vecs[23] = v(0, 8'h00, 1, 1, 0, 8'h08, 32'h66,   0, 0, 32'h0,   1, 0, 1, 1, 1, wd(1, 0, 32'h55));
    vecs[24] = v(0, 8'h00, 0, 0, 0, 8'h00, 32'h0,    0, 0, 32'h0,   1, 0, 1, 1, 2, wd(1, 0, 32'h66));
    vecs[25] = v(0, 8'h00, 0, 0, 0, 8'h00, 32'h0,    0, 0, 32'h0,   1, 0, 0, 0, 0, 0);
    vecs[26] = v(1, 8'h04, 0, 0, 0, 8'h00, 32'h0,    0, 0, 32'h0,   1, 0, 1, 0, 1, 0);
    vecs[27] = v(0, 8'h00, 0, 0, 0, 8'h00, 32'h0,    1, 1, 32'h55,  1, 0, 0, 0, 0, 0);

    // Outputs while reset is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arr_en", 64'(arr_en), 64'd0);
    chk("rst_arr_we", 64'(arr_we), 64'd0);
    chk("rst_fetch_vld", 64'(fetch_vld), 64'd0);
    chk("rst_upd_ready", 64'(upd_ready), 64'd0);
    chk("rst_upd_drop", 64'(upd_drop), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    next_cycle();
    reset = 1'b1;
    check_init_sweep("init");

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].freq, vecs[i].fpc, vecs[i].exv, vecs[i].ext, vecs[i].exp,
            vecs[i].expc, vecs[i].tgt);
      @(negedge clk);
      chk($sformatf("v%0d_vld", i), 64'(fetch_vld), 64'(vecs[i].vld));
      chk($sformatf("v%0d_hit", i), 64'(fetch_hit), 64'(vecs[i].hit));
      chk($sformatf("v%0d_bta", i), 64'(fetch_bta), 64'(vecs[i].bta));
      chk($sformatf("v%0d_rdy", i), 64'(upd_ready), 64'(vecs[i].rdy));
      chk($sformatf("v%0d_drop", i), 64'(upd_drop), 64'(vecs[i].drop));
      chk($sformatf("v%0d_en", i), 64'(arr_en), 64'(vecs[i].en));
      chk($sformatf("v%0d_we", i), 64'(arr_we), 64'(vecs[i].we));
      if (vecs[i].en) chk($sformatf("v%0d_idx", i), 64'(arr_idx), 64'(vecs[i].idx));
      if (vecs[i].we) chk($sformatf("v%0d_wd", i), 64'(arr_wdata), 64'(vecs[i].wd));
      next_cycle();
    end

    // Fill the FIFO behind a held fetch, then reset before it drains
    drive(1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 8'h28, 32'h80);
    next_cycle();
    drive(1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 8'h3C, 32'hC0);
    next_cycle();
    drive(1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_arr_en", 64'(arr_en), 64'd0);
    chk("mid_rst_upd_ready", 64'(upd_ready), 64'd0);
    chk("mid_rst_init_done", 64'(init_done), 64'd0);
    chk("mid_rst_fetch_vld", 64'(fetch_vld), 64'd0);
    next_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    next_cycle();
    reset = 1'b1;
    check_init_sweep("reinit");
    @(negedge clk);
    chk("post_rst_en", 64'(arr_en), 64'd0);
    chk("post_rst_ready", 64'(upd_ready), 64'd1);
    next_cycle();
    drive(1'b1, 8'h28, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("post_rst_rd_en", 64'(arr_en), 64'd1);
    chk("post_rst_rd_we", 64'(arr_we), 64'd0);
    chk("post_rst_rd_idx", 64'(arr_idx), 64'd2);
    next_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("post_rst_vld", 64'(fetch_vld), 64'd1);
    chk("post_rst_hit", 64'(fetch_hit), 64'd0);
    chk("post_rst_en2", 64'(arr_en), 64'd0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
